// File: rtl/bank_timing_ctrl.sv
// Purpose : per-bank DRAM timing controller (tRCD/tCL/tWR/tRP/tRFC/tRAS, deferred and auto precharge).
// Latency : fully registered; a command sampled in cycle n is reflected on every output in cycle n+1.
// Backpr. : none; commands are never stalled, an illegal or conflicting command is dropped with cmd_err.
//
// Ports   : clk, rst (synchronous, active-high)
//           ACT RD RDA WR WRA PR PRA REF BST  - one-hot command strobes from the command decoder
//           state[2:0], wait_ct[CTR_W-1:0], bank_open, cmd_ack, cmd_err, rd_valid
// Option  : define BANK_TIMING_STATS_EN to add act_count[15:0] / err_count[15:0] saturating counters.
module bank_timing_ctrl #(
    parameter int CTR_W = 8,
    parameter int T_RCD = 22,
    parameter int T_CL  = 14,
    parameter int T_WR  = 24,
    parameter int T_RP  = 20,
    parameter int T_RFC = 243,
    parameter int T_RAS = 52
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ACT,
    input  logic             RD,
    input  logic             RDA,
    input  logic             WR,
    input  logic             WRA,
    input  logic             PR,
    input  logic             PRA,
    input  logic             REF,
    input  logic             BST,
    output logic [2:0]       state,
    output logic [CTR_W-1:0] wait_ct,
    output logic             bank_open,
    output logic             cmd_ack,
    output logic             cmd_err,
    output logic             rd_valid
`ifdef BANK_TIMING_STATS_EN
    ,
    output logic [15:0]      act_count,
    output logic [15:0]      err_count
`endif
);

    // Every timing value is loaded as T_x-1, so it must be representable and non-zero.
    localparam int T_MAX = (1 << CTR_W) - 1;

    generate
        if (T_RCD < 1 || T_RCD > T_MAX || T_CL  < 1 || T_CL  > T_MAX ||
            T_WR  < 1 || T_WR  > T_MAX || T_RP  < 1 || T_RP  > T_MAX ||
            T_RFC < 1 || T_RFC > T_MAX || T_RAS < 1 || T_RAS > T_MAX) begin : g_bad_timing
            $error("bank_timing_ctrl: timing parameter outside 1..2^CTR_W-1");
        end
    endgenerate

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_ACTIVATING  = 3'd1;
    localparam logic [2:0] S_BANK_ACTIVE = 3'd2;
    localparam logic [2:0] S_READING     = 3'd3;
    localparam logic [2:0] S_WRITING     = 3'd4;
    localparam logic [2:0] S_PRECHARGING = 3'd5;
    localparam logic [2:0] S_REFRESHING  = 3'd6;

    localparam logic [CTR_W-1:0] L_ONE = CTR_W'(1);
    localparam logic [CTR_W-1:0] L_RCD = CTR_W'(T_RCD - 1);
    localparam logic [CTR_W-1:0] L_CL  = CTR_W'(T_CL - 1);
    localparam logic [CTR_W-1:0] L_WR  = CTR_W'(T_WR - 1);
    localparam logic [CTR_W-1:0] L_RP  = CTR_W'(T_RP - 1);
    localparam logic [CTR_W-1:0] L_RFC = CTR_W'(T_RFC - 1);
    localparam logic [CTR_W-1:0] L_RAS = CTR_W'(T_RAS - 1);

    logic [2:0]       r_state;
    logic [CTR_W-1:0] r_wait_ct;
    logic [CTR_W-1:0] r_ras_ct;
    logic             r_pre_pend;
    logic             r_ap_flag;
    logic             r_bank_open;
    logic             r_cmd_ack;
    logic             r_cmd_err;
    logic             r_rd_valid;

    logic [8:0]       w_cmd;
    logic             w_any;
    logic             w_one;
    logic             w_act;
    logic             w_ref;
    logic             w_rd;
    logic             w_wr;
    logic             w_pr;
    logic             w_bst;
    logic             w_done;
    logic             w_ras_done;

    logic [2:0]       w_nxt_state;
    logic [CTR_W-1:0] w_nxt_wait;
    logic             w_nxt_pre;
    logic             w_nxt_ap;
    logic             w_legal;
    logic             w_err;
    logic             w_act_ok;

    // A command only counts when exactly one strobe is high; two or more is a NOP plus error.
    assign w_cmd      = {ACT, RD, RDA, WR, WRA, PR, PRA, REF, BST};
    assign w_any      = |w_cmd;
    assign w_one      = w_any && ((w_cmd & (w_cmd - 9'd1)) == 9'd0);
    assign w_act      = w_one && ACT;
    assign w_ref      = w_one && REF;
    assign w_rd       = w_one && (RD || RDA);
    assign w_wr       = w_one && (WR || WRA);
    assign w_pr       = w_one && (PR || PRA);
    assign w_bst      = w_one && BST;
    assign w_done     = (r_wait_ct == '0);
    assign w_ras_done = (r_ras_ct == '0);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_wait  = w_done ? '0 : (r_wait_ct - L_ONE);
        w_nxt_pre   = r_pre_pend;
        w_nxt_ap    = r_ap_flag;
        w_legal     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_act) begin
                    w_legal     = 1'b1;
                    w_nxt_state = S_ACTIVATING;
                    w_nxt_wait  = L_RCD;
                end else if (w_ref) begin
                    w_legal     = 1'b1;
                    w_nxt_state = S_REFRESHING;
                    w_nxt_wait  = L_RFC;
                end else if (w_pr) begin
                    // Precharging an already closed bank is harmless: acknowledge, do nothing.
                    w_legal = 1'b1;
                end
            end

            S_ACTIVATING: begin
                if (w_done) begin
                    w_nxt_state = S_BANK_ACTIVE;
                end
            end

            S_BANK_ACTIVE: begin
                if ((w_rd || w_wr) && !r_pre_pend) begin
                    w_legal     = 1'b1;
                    w_nxt_state = w_rd ? S_READING : S_WRITING;
                    w_nxt_wait  = w_rd ? L_CL : L_WR;
                    w_nxt_ap    = RDA || WRA;
                end else begin
                    if (w_pr) begin
                        w_legal = 1'b1;
                    end
                    // A precharge (fresh or deferred) is released as soon as tRAS has elapsed;
                    // otherwise a fresh one is parked in pre_pend until it has.
                    if ((r_pre_pend || w_pr) && w_ras_done) begin
                        w_nxt_state = S_PRECHARGING;
                        w_nxt_wait  = L_RP;
                        w_nxt_pre   = 1'b0;
                    end else if (w_pr) begin
                        w_nxt_pre = 1'b1;
                    end
                end
            end

            S_READING, S_WRITING: begin
                if (w_bst && !r_ap_flag) begin
                    w_legal     = 1'b1;
                    w_nxt_state = S_BANK_ACTIVE;
                    w_nxt_wait  = '0;
                end else if (w_done) begin
                    w_nxt_state = S_BANK_ACTIVE;
                    if (r_ap_flag) begin
                        w_nxt_pre = 1'b1;
                        w_nxt_ap  = 1'b0;
                    end
                end
            end

            S_PRECHARGING, S_REFRESHING: begin
                if (w_done) begin
                    w_nxt_state = S_IDLE;
                end
            end

            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_wait  = '0;
                w_nxt_pre   = 1'b0;
                w_nxt_ap    = 1'b0;
            end
        endcase
    end

    assign w_err    = w_any && !w_legal;
    assign w_act_ok = w_legal && w_act;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wait_ct   <= '0;
            r_ras_ct    <= '0;
            r_pre_pend  <= 1'b0;
            r_ap_flag   <= 1'b0;
            r_bank_open <= 1'b0;
            r_cmd_ack   <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_wait_ct   <= w_nxt_wait;
            r_pre_pend  <= w_nxt_pre;
            r_ap_flag   <= w_nxt_ap;
            r_bank_open <= (w_nxt_state >= S_ACTIVATING) && (w_nxt_state <= S_WRITING);
            r_cmd_ack   <= w_legal;
            r_cmd_err   <= w_err;
            // Pulse lands on the cycle whose wait_ct reads 0 inside READING.
            r_rd_valid  <= (w_nxt_state == S_READING) && (w_nxt_wait == '0);
            // tRAS runs from ACT across reads/writes; it only restarts on the next ACT.
            if (w_act_ok) begin
                r_ras_ct <= L_RAS;
            end else if (r_bank_open && !w_ras_done) begin
                r_ras_ct <= r_ras_ct - L_ONE;
            end
        end
    end

    assign state     = r_state;
    assign wait_ct   = r_wait_ct;
    assign bank_open = r_bank_open;
    assign cmd_ack   = r_cmd_ack;
    assign cmd_err   = r_cmd_err;
    assign rd_valid  = r_rd_valid;

`ifdef BANK_TIMING_STATS_EN
    logic [15:0] r_act_count;
    logic [15:0] r_err_count;

    // Counters move on the same edge that raises cmd_ack / cmd_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_count <= '0;
            r_err_count <= '0;
        end else begin
            if (w_act_ok && (r_act_count != 16'hFFFF)) begin
                r_act_count <= r_act_count + 16'd1;
            end
            if (w_err && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign act_count = r_act_count;
    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_bank_timing_ctrl.sv
// Purpose : self-checking bench for bank_timing_ctrl; directed timeline checks plus random commands.
// Latency : reference model keeps absolute cycle deadlines; outputs compared on every falling edge.
// Backpr. : none; stimulus is applied one command vector per cycle.
`timescale 1ns/1ps
module tb_bank_timing_ctrl;

    localparam int CTR_W = 8;
    localparam int T_RCD = 22;
    localparam int T_CL  = 14;
    localparam int T_WR  = 24;
    localparam int T_RP  = 20;
    localparam int T_RFC = 243;
    localparam int T_RAS = 52;

    localparam logic [8:0] C_NOP = 9'h000;
    localparam logic [8:0] C_ACT = 9'h100;
    localparam logic [8:0] C_RD  = 9'h080;
    localparam logic [8:0] C_RDA = 9'h040;
    localparam logic [8:0] C_WR  = 9'h020;
    localparam logic [8:0] C_WRA = 9'h010;
    localparam logic [8:0] C_PR  = 9'h008;
    localparam logic [8:0] C_PRA = 9'h004;
    localparam logic [8:0] C_REF = 9'h002;
    localparam logic [8:0] C_BST = 9'h001;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [8:0]       cmd = '0;
    logic             ACT, RD, RDA, WR, WRA, PR, PRA, REF, BST;
    logic [2:0]       state;
    logic [CTR_W-1:0] wait_ct;
    logic             bank_open, cmd_ack, cmd_err, rd_valid;
`ifdef BANK_TIMING_STATS_EN
    logic [15:0]      act_count, err_count;
`endif

    assign {ACT, RD, RDA, WR, WRA, PR, PRA, REF, BST} = cmd;

    always #5 clk = ~clk;

    bank_timing_ctrl #(
        .CTR_W(CTR_W), .T_RCD(T_RCD), .T_CL(T_CL), .T_WR(T_WR),
        .T_RP(T_RP), .T_RFC(T_RFC), .T_RAS(T_RAS)
    ) dut (
        .clk(clk), .rst(rst),
        .ACT(ACT), .RD(RD), .RDA(RDA), .WR(WR), .WRA(WRA),
        .PR(PR), .PRA(PRA), .REF(REF), .BST(BST),
        .state(state), .wait_ct(wait_ct), .bank_open(bank_open),
        .cmd_ack(cmd_ack), .cmd_err(cmd_err), .rd_valid(rd_valid)
`ifdef BANK_TIMING_STATS_EN
        , .act_count(act_count), .err_count(err_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Timed states are tracked by the absolute cycle of their last cycle (m_exit);
    // tRAS by the absolute cycle from which a precharge may start (m_ras0).
    bit         m_ok = 1'b0;
    int         m_cyc, m_exit, m_ras0;
    logic [2:0] m_st;
    bit         m_pre, m_ap, m_ack, m_err, m_rdv;
    int         m_acts, m_errs;

    function automatic bit is_timed(input logic [2:0] s);
        return (s == 3'd1) || (s == 3'd3) || (s == 3'd4) || (s == 3'd5) || (s == 3'd6);
    endfunction

    task automatic model_step();
        int         c, n, nx;
        logic [2:0] ns;
        bit         one, done, ras0, legal, is_rd, is_wr, is_pr;
        c     = m_cyc;
        n     = $countones(cmd);
        one   = (n == 1);
        done  = is_timed(m_st) && (c == m_exit);
        ras0  = (c >= m_ras0);
        is_rd = one && (cmd == C_RD || cmd == C_RDA);
        is_wr = one && (cmd == C_WR || cmd == C_WRA);
        is_pr = one && (cmd == C_PR || cmd == C_PRA);
        legal = 1'b0;
        ns    = m_st;
        nx    = m_exit;
        case (m_st)
            3'd0: begin
                if (one && cmd == C_ACT) begin
                    legal = 1; ns = 3'd1; nx = c + T_RCD; m_ras0 = c + T_RAS;
                    if (m_acts < 65535) m_acts++;
                end else if (one && cmd == C_REF) begin
                    legal = 1; ns = 3'd6; nx = c + T_RFC;
                end else if (is_pr) begin
                    legal = 1;
                end
            end
            3'd1: if (done) ns = 3'd2;
            3'd2: begin
                if ((is_rd || is_wr) && !m_pre) begin
                    legal = 1;
                    ns    = is_rd ? 3'd3 : 3'd4;
                    nx    = c + (is_rd ? T_CL : T_WR);
                    m_ap  = (cmd == C_RDA || cmd == C_WRA);
                end else begin
                    if (is_pr) begin legal = 1; m_pre = 1; end
                    if (m_pre && ras0) begin ns = 3'd5; nx = c + T_RP; m_pre = 0; end
                end
            end
            3'd3, 3'd4: begin
                if (one && cmd == C_BST && !m_ap) begin
                    legal = 1; ns = 3'd2;
                end else if (done) begin
                    ns = 3'd2;
                    if (m_ap) begin m_pre = 1; m_ap = 0; end
                end
            end
            default: if (done) ns = 3'd0;
        endcase
        m_ack = legal;
        m_err = (n != 0) && !legal;
        if (m_err && m_errs < 65535) m_errs++;
        m_rdv  = (ns == 3'd3) && (nx == c + 1);
        m_st   = ns;
        m_exit = nx;
        m_cyc  = c + 1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_ok = 1; m_cyc = 0; m_exit = 0; m_ras0 = 0; m_st = 3'd0;
                m_pre = 0; m_ap = 0; m_ack = 0; m_err = 0; m_rdv = 0;
                m_acts = 0; m_errs = 0;
            end else if (m_ok) begin
                model_step();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_ok) begin
                chk("model state", state, m_st);
                chk("model wait_ct", wait_ct, is_timed(m_st) ? (m_exit - m_cyc) : 0);
                chk("model bank_open", bank_open, (m_st >= 3'd1) && (m_st <= 3'd4));
                chk("model cmd_ack", cmd_ack, m_ack);
                chk("model cmd_err", cmd_err, m_err);
                chk("model rd_valid", rd_valid, m_rdv);
`ifdef BANK_TIMING_STATS_EN
                chk("model act_count", act_count, m_acts);
                chk("model err_count", err_count, m_errs);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    int k;

    task automatic do_reset();
        rst = 1'b1;
        cmd = C_NOP;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        k   = 0;
    endtask

    // Drive the inputs for cycle k, then move to the falling edge of cycle k+1.
    task automatic step(input logic [8:0] c);
        cmd = c;
        @(negedge clk);
        k++;
    endtask

    task automatic run_to(input int target);
        while (k < target) step(C_NOP);
    endtask

    function automatic logic [8:0] rand_cmd();
        int         r;
        int         a;
        int         b;
        logic [8:0] v;
        v = '0;
        r = $urandom_range(0, 99);
        if (r >= 55 && r < 95) begin
            v[$urandom_range(0, 8)] = 1'b1;
        end else if (r >= 95) begin
            a = $urandom_range(0, 8);
            b = (a + $urandom_range(1, 8)) % 9;
            v[a] = 1'b1;
            v[b] = 1'b1;
        end
        return v;
    endfunction

    initial begin
        // Activate / close with deferred precharge.
        do_reset();
        chk("reset state", state, 0);
        chk("reset wait_ct", wait_ct, 0);
        chk("reset bank_open", bank_open, 0);
        step(C_ACT);
        chk("t1 ack@1", cmd_ack, 1);
        chk("t1 state@1", state, 1);
        chk("t1 wait@1", wait_ct, 21);
        run_to(23); chk("t1 state@23", state, 2);
        step(C_PR); chk("t1 ack@24", cmd_ack, 1);
        run_to(52); chk("t1 state@52", state, 2);
        step(C_NOP); chk("t1 state@53", state, 5); chk("t1 wait@53", wait_ct, 19);
        run_to(72); chk("t1 state@72", state, 5); chk("t1 wait@72", wait_ct, 0);
        step(C_NOP); chk("t1 state@73", state, 0); chk("t1 open@73", bank_open, 0);

        // Reads, then immediate precharge once tRAS has expired.
        do_reset();
        step(C_ACT);
        run_to(23);
        step(C_RD); chk("t2 state@24", state, 3); chk("t2 wait@24", wait_ct, 13);
        run_to(37); chk("t2 rd_valid@37", rd_valid, 1); chk("t2 state@37", state, 3);
        step(C_NOP); chk("t2 state@38", state, 2); chk("t2 rd_valid@38", rd_valid, 0);
        step(C_RD); chk("t2 state@39", state, 3); chk("t2 ack@39", cmd_ack, 1);
        run_to(52); chk("t2 rd_valid@52", rd_valid, 1);
        step(C_NOP); chk("t2 state@53", state, 2);
        step(C_PR); chk("t2 state@54", state, 5); chk("t2 ack@54", cmd_ack, 1);

        // Auto-precharge write with tRAS hold-off.
        do_reset();
        step(C_ACT);
        run_to(23);
        step(C_WRA); chk("t3 state@24", state, 4); chk("t3 wait@24", wait_ct, 23);
        run_to(30);
        step(C_BST); chk("t3 bst err@31", cmd_err, 1); chk("t3 state@31", state, 4);
        run_to(47); chk("t3 state@47", state, 4);
        step(C_NOP); chk("t3 state@48", state, 2);
        step(C_WR); chk("t3 wr pend err@49", cmd_err, 1); chk("t3 state@49", state, 2);
        run_to(52); chk("t3 state@52", state, 2);
        step(C_NOP); chk("t3 state@53", state, 5);
        run_to(73); chk("t3 state@73", state, 0);

        // Illegal and conflicting commands.
        do_reset();
        step(C_RD); chk("t4 rd idle err", cmd_err, 1); chk("t4 rd idle state", state, 0);
        step(C_ACT | C_REF); chk("t4 multi err", cmd_err, 1); chk("t4 multi state", state, 0);
        chk("t4 multi ack", cmd_ack, 0);
        step(C_PRA); chk("t4 pra idle ack", cmd_ack, 1); chk("t4 pra idle err", cmd_err, 0);
        step(C_BST); chk("t4 bst idle err", cmd_err, 1);

        // Refresh, then reset in the middle of a refresh.
        do_reset();
        step(C_REF); chk("t5 state@1", state, 6); chk("t5 wait@1", wait_ct, 242);
        chk("t5 open@1", bank_open, 0);
        run_to(243); chk("t5 state@243", state, 6); chk("t5 wait@243", wait_ct, 0);
        step(C_NOP); chk("t5 state@244", state, 0);
        do_reset();
        step(C_REF);
        run_to(100); chk("t5 wait@100", wait_ct, 143);
        rst = 1'b1;
        step(C_ACT);
        chk("t5 rst state@101", state, 0); chk("t5 rst wait@101", wait_ct, 0);
        chk("t5 rst ack@101", cmd_ack, 0); chk("t5 rst err@101", cmd_err, 0);
        chk("t5 rst rdv@101", rd_valid, 0);
        rst = 1'b0;

`ifdef BANK_TIMING_STATS_EN
        do_reset();
        step(C_ACT);
        step(C_ACT);
        run_to(23);
        step(C_PR);
        run_to(73);
        step(C_ACT);
        step(C_REF);
        run_to(96);
        step(C_PR);
        run_to(146);
        step(C_ACT);
        chk("stats act_count", act_count, 3);
        chk("stats err_count", err_count, 2);
        rst = 1'b1;
        step(C_NOP);
        chk("stats act clr", act_count, 0);
        chk("stats err clr", err_count, 0);
        rst = 1'b0;
`endif

        // Random commands against the model, with occasional resets.
        do_reset();
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 2999) == 0) begin
                rst = 1'b1;
                step(C_NOP);
                rst = 1'b0;
            end else begin
                step(rand_cmd());
            end
        end
        cmd = C_NOP;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t, limit 2000000", $time);
        $fatal(1, "watchdog");
    end

endmodule
